// File: rtl/interrupt_controller.sv
// Five-source 8051-style interrupt controller: INTx synchronizers and flags,
// two-level priority arbitration, request/acknowledge FSM and in-service tracking.
module interrupt_controller #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'h0003
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_ie,
    input  logic [7:0]  i_ip,
    input  logic        i_it0,
    input  logic        i_it1,
    input  logic        i_int0_n,
    input  logic        i_int1_n,
    input  logic        i_tf0,
    input  logic        i_tf1,
    input  logic        i_ri,
    input  logic        i_ti,
    input  logic        i_clr_ie0,
    input  logic        i_clr_ie1,
    input  logic        i_ack,
    input  logic        i_reti,
    output logic        o_irq,
    output logic [15:0] o_vector,
    output logic        o_clr_tf0,
    output logic        o_clr_tf1,
    output logic        o_ie0,
    output logic        o_ie1,
    output logic        o_isr_hi,
    output logic        o_isr_lo
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                 state;
    logic [2:0]             lat_idx;
    logic                   lat_lvl;
    logic [SYNC_STAGES-1:0] sync0_q;
    logic [SYNC_STAGES-1:0] sync1_q;
    logic                   prev0_q;
    logic                   prev1_q;
    logic                   int0_s;
    logic                   int1_s;
    logic                   fall0;
    logic                   fall1;
    logic                   hw_clr_ie0;
    logic                   hw_clr_ie1;
    logic [4:0]             flags;
    logic [4:0]             elig;
    logic [4:0]             hi_cand;
    logic [4:0]             lo_cand;
    logic                   cand_valid;
    logic [2:0]             cand_idx;
    logic                   cand_lvl;
    logic                   lat_elig;
    logic                   isr_hi_n;
    logic                   isr_lo_n;
    logic                   ack_req;
    logic                   unused_bits;

    assign unused_bits = &{1'b0, i_ie[6:5], i_ip[7:5]};

    assign int0_s = sync0_q[SYNC_STAGES-1];
    assign int1_s = sync1_q[SYNC_STAGES-1];
    assign fall0  = prev0_q & ~int0_s;
    assign fall1  = prev1_q & ~int1_s;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync0_q <= '1;
            sync1_q <= '1;
            prev0_q <= 1'b1;
            prev1_q <= 1'b1;
        end else begin
            sync0_q <= {sync0_q[SYNC_STAGES-2:0], i_int0_n};
            sync1_q <= {sync1_q[SYNC_STAGES-2:0], i_int1_n};
            prev0_q <= int0_s;
            prev1_q <= int1_s;
        end
    end

    assign ack_req    = (state == REQ) && i_ack;
    assign hw_clr_ie0 = ack_req && (lat_idx == 3'd0);
    assign hw_clr_ie1 = ack_req && (lat_idx == 3'd2);

    // Edge mode: a new falling edge wins over any clear in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ie0 <= 1'b0;
            o_ie1 <= 1'b0;
        end else begin
            if (i_it0) begin
                if (fall0)
                    o_ie0 <= 1'b1;
                else if (i_clr_ie0 || hw_clr_ie0)
                    o_ie0 <= 1'b0;
            end else begin
                o_ie0 <= ~int0_s;
            end
            if (i_it1) begin
                if (fall1)
                    o_ie1 <= 1'b1;
                else if (i_clr_ie1 || hw_clr_ie1)
                    o_ie1 <= 1'b0;
            end else begin
                o_ie1 <= ~int1_s;
            end
        end
    end

    assign flags   = {i_ri | i_ti, i_tf1, o_ie1, i_tf0, o_ie0};
    assign elig    = flags & i_ie[4:0] & {5{i_ie[7]}};
    assign hi_cand = elig & i_ip[4:0];
    assign lo_cand = elig & ~i_ip[4:0];
    assign lat_elig = elig[lat_idx];

    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = 3'd0;
        cand_lvl   = 1'b0;
        if (hi_cand != 5'd0 && !o_isr_hi) begin
            cand_valid = 1'b1;
            cand_lvl   = 1'b1;
            for (int i = 4; i >= 0; i--)
                if (hi_cand[i]) cand_idx = 3'(i);
        end else if (lo_cand != 5'd0 && !o_isr_hi && !o_isr_lo) begin
            cand_valid = 1'b1;
            for (int i = 4; i >= 0; i--)
                if (lo_cand[i]) cand_idx = 3'(i);
        end
    end

    // RETI retires the innermost level before an acknowledge in the same cycle marks its own.
    always_comb begin
        isr_hi_n = o_isr_hi;
        isr_lo_n = o_isr_lo;
        if (i_reti) begin
            if (o_isr_hi)
                isr_hi_n = 1'b0;
            else if (o_isr_lo)
                isr_lo_n = 1'b0;
        end
        if (ack_req) begin
            if (lat_lvl)
                isr_hi_n = 1'b1;
            else
                isr_lo_n = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            lat_idx   <= 3'd0;
            lat_lvl   <= 1'b0;
            o_irq     <= 1'b0;
            o_vector  <= 16'h0000;
            o_clr_tf0 <= 1'b0;
            o_clr_tf1 <= 1'b0;
            o_isr_hi  <= 1'b0;
            o_isr_lo  <= 1'b0;
        end else begin
            o_clr_tf0 <= 1'b0;
            o_clr_tf1 <= 1'b0;
            o_isr_hi  <= isr_hi_n;
            o_isr_lo  <= isr_lo_n;
            case (state)
                IDLE: begin
                    if (cand_valid && !i_reti) begin
                        state    <= REQ;
                        lat_idx  <= cand_idx;
                        lat_lvl  <= cand_lvl;
                        o_irq    <= 1'b1;
                        o_vector <= VEC_BASE + {10'b0, cand_idx, 3'b000};
                    end
                end
                REQ: begin
                    if (i_ack) begin
                        state     <= IDLE;
                        o_irq     <= 1'b0;
                        o_clr_tf0 <= (lat_idx == 3'd1);
                        o_clr_tf1 <= (lat_idx == 3'd3);
                    end else if (!lat_elig) begin
                        state <= IDLE;
                        o_irq <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    o_irq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: hand-computed expectations for
// arbitration, priority nesting, INTx sync latency, withdrawal and reset.
module tb_interrupt_controller;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_ie;
    logic [7:0]  i_ip;
    logic        i_it0;
    logic        i_it1;
    logic        i_int0_n;
    logic        i_int1_n;
    logic        i_tf0;
    logic        i_tf1;
    logic        i_ri;
    logic        i_ti;
    logic        i_clr_ie0;
    logic        i_clr_ie1;
    logic        i_ack;
    logic        i_reti;
    logic        o_irq;
    logic [15:0] o_vector;
    logic        o_clr_tf0;
    logic        o_clr_tf1;
    logic        o_ie0;
    logic        o_ie1;
    logic        o_isr_hi;
    logic        o_isr_lo;

    int n_checks = 0;
    int n_errors = 0;

    interrupt_controller #(
        .SYNC_STAGES(2),
        .VEC_BASE   (16'h0003)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ie      (i_ie),
        .i_ip      (i_ip),
        .i_it0     (i_it0),
        .i_it1     (i_it1),
        .i_int0_n  (i_int0_n),
        .i_int1_n  (i_int1_n),
        .i_tf0     (i_tf0),
        .i_tf1     (i_tf1),
        .i_ri      (i_ri),
        .i_ti      (i_ti),
        .i_clr_ie0 (i_clr_ie0),
        .i_clr_ie1 (i_clr_ie1),
        .i_ack     (i_ack),
        .i_reti    (i_reti),
        .o_irq     (o_irq),
        .o_vector  (o_vector),
        .o_clr_tf0 (o_clr_tf0),
        .o_clr_tf1 (o_clr_tf1),
        .o_ie0     (o_ie0),
        .o_ie1     (o_ie1),
        .o_isr_hi  (o_isr_hi),
        .o_isr_lo  (o_isr_lo)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        i_rst = 1'b1; i_ie = 8'h00; i_ip = 8'h00; i_it0 = 1'b0; i_it1 = 1'b0;
        i_int0_n = 1'b1; i_int1_n = 1'b1; i_tf0 = 1'b0; i_tf1 = 1'b0;
        i_ri = 1'b0; i_ti = 1'b0; i_clr_ie0 = 1'b0; i_clr_ie1 = 1'b0;
        i_ack = 1'b0; i_reti = 1'b0;
        tick(2);
        chk("rst_irq", 32'(o_irq), 32'd0);
        chk("rst_vec", 32'(o_vector), 32'h0000);
        chk("rst_isr", 32'({o_isr_hi, o_isr_lo}), 32'd0);
        chk("rst_ie", 32'({o_ie1, o_ie0}), 32'd0);
        chk("rst_clr", 32'({o_clr_tf1, o_clr_tf0}), 32'd0);
        i_rst = 1'b0;
        tick(1);

        // ack with nothing pending does nothing
        i_ack = 1'b1; tick(1); i_ack = 1'b0;
        chk("idle_ack_isr", 32'({o_isr_hi, o_isr_lo}), 32'd0);

        // single timer 0 request, ack, clear pulse, reti
        i_ie = 8'h82; i_tf0 = 1'b1;
        chk("t0_irq_pre", 32'(o_irq), 32'd0);
        tick(1);
        chk("t0_irq", 32'(o_irq), 32'd1);
        chk("t0_vec", 32'(o_vector), 32'h000B);
        i_ack = 1'b1; tick(1); i_ack = 1'b0;
        chk("t0_ack_irq", 32'(o_irq), 32'd0);
        chk("t0_clr", 32'(o_clr_tf0), 32'd1);
        chk("t0_isr_lo", 32'(o_isr_lo), 32'd1);
        i_tf0 = 1'b0;
        tick(1);
        chk("t0_clr_once", 32'(o_clr_tf0), 32'd0);
        i_reti = 1'b1; tick(1); i_reti = 1'b0;
        chk("t0_reti", 32'(o_isr_lo), 32'd0);

        // simultaneous timers: index order, then IP
        i_ie = 8'h8A; i_ip = 8'h00; i_tf0 = 1'b1; i_tf1 = 1'b1;
        tick(1);
        chk("both_ip0_vec", 32'(o_vector), 32'h000B);
        i_tf0 = 1'b0; i_tf1 = 1'b0;
        tick(1);
        chk("both_withdraw", 32'(o_irq), 32'd0);
        i_ip = 8'h08; i_tf0 = 1'b1; i_tf1 = 1'b1;
        tick(1);
        chk("both_ip8_irq", 32'(o_irq), 32'd1);
        chk("both_ip8_vec", 32'(o_vector), 32'h001B);
        i_tf0 = 1'b0; i_tf1 = 1'b0;
        tick(1);

        // nesting: low TF0 in service, high TF1 preempts, second low blocked until two retis
        i_tf0 = 1'b1;
        tick(1);
        chk("nest_t0_vec", 32'(o_vector), 32'h000B);
        i_ack = 1'b1; tick(1); i_ack = 1'b0; i_tf0 = 1'b0;
        chk("nest_isr_lo", 32'({o_isr_hi, o_isr_lo}), 32'b01);
        i_tf1 = 1'b1;
        tick(1);
        chk("nest_t1_irq", 32'(o_irq), 32'd1);
        chk("nest_t1_vec", 32'(o_vector), 32'h001B);
        i_ack = 1'b1; tick(1); i_ack = 1'b0; i_tf1 = 1'b0;
        chk("nest_clr_tf1", 32'(o_clr_tf1), 32'd1);
        chk("nest_isr_both", 32'({o_isr_hi, o_isr_lo}), 32'b11);
        i_tf0 = 1'b1;
        tick(2);
        chk("nest_blocked", 32'(o_irq), 32'd0);
        i_reti = 1'b1; tick(1); i_reti = 1'b0;
        chk("nest_reti1", 32'({o_isr_hi, o_isr_lo}), 32'b01);
        tick(1);
        chk("nest_still_blk", 32'(o_irq), 32'd0);
        i_reti = 1'b1; tick(1); i_reti = 1'b0;
        chk("nest_reti2", 32'({o_isr_hi, o_isr_lo}), 32'b00);
        chk("nest_reti_nostart", 32'(o_irq), 32'd0);
        tick(1);
        chk("nest_unblk_irq", 32'(o_irq), 32'd1);
        chk("nest_unblk_vec", 32'(o_vector), 32'h000B);
        i_ack = 1'b1; tick(1); i_ack = 1'b0; i_tf0 = 1'b0;
        i_reti = 1'b1; tick(1); i_reti = 1'b0;
        chk("nest_end_isr", 32'({o_isr_hi, o_isr_lo}), 32'd0);

        // INT0 edge mode: sync latency, hold, vectoring clears flag
        i_ie = 8'h00; i_ip = 8'h00; i_it0 = 1'b1;
        i_int0_n = 1'b0;
        tick(2);
        chk("ie0_lat2", 32'(o_ie0), 32'd0);
        tick(1);
        chk("ie0_lat3", 32'(o_ie0), 32'd1);
        i_int0_n = 1'b1;
        tick(4);
        chk("ie0_held", 32'(o_ie0), 32'd1);
        chk("ie0_noirq", 32'(o_irq), 32'd0);
        i_ie = 8'h81;
        tick(1);
        chk("ie0_irq", 32'(o_irq), 32'd1);
        chk("ie0_vec", 32'(o_vector), 32'h0003);
        i_ack = 1'b1; tick(1); i_ack = 1'b0;
        chk("ie0_ack_clr", 32'(o_ie0), 32'd0);
        chk("ie0_isr_lo", 32'(o_isr_lo), 32'd1);
        i_reti = 1'b1; tick(1); i_reti = 1'b0;
        i_ie = 8'h00;

        // software clear coinciding with a new edge leaves the flag set
        i_int0_n = 1'b0; tick(1); i_int0_n = 1'b1;
        tick(1);
        i_clr_ie0 = 1'b1; tick(1);
        chk("ie0_set_wins", 32'(o_ie0), 32'd1);
        tick(1); i_clr_ie0 = 1'b0;
        chk("ie0_sw_clr", 32'(o_ie0), 32'd0);

        // INT1 level mode follows the pin with the same latency
        i_it1 = 1'b0; i_int1_n = 1'b0;
        tick(2);
        chk("ie1_lvl_lat2", 32'(o_ie1), 32'd0);
        tick(1);
        chk("ie1_lvl_set", 32'(o_ie1), 32'd1);
        i_int1_n = 1'b1;
        tick(3);
        chk("ie1_lvl_clr", 32'(o_ie1), 32'd0);

        // withdrawal: ET1 cleared before ack
        i_ie = 8'h88; i_tf1 = 1'b1;
        tick(1);
        chk("wd_irq", 32'(o_irq), 32'd1);
        chk("wd_vec", 32'(o_vector), 32'h001B);
        i_ie = 8'h80;
        tick(1);
        chk("wd_drop", 32'(o_irq), 32'd0);
        tick(1);
        chk("wd_no_clr", 32'(o_clr_tf1), 32'd0);
        chk("wd_isr", 32'({o_isr_hi, o_isr_lo}), 32'd0);
        i_tf1 = 1'b0;

        // reset mid-request drops irq at once, no clear pulse afterwards
        i_ie = 8'h82; i_tf0 = 1'b1;
        tick(1);
        chk("rq_irq", 32'(o_irq), 32'd1);
        i_ack = 1'b1; i_rst = 1'b1;
        #1;
        chk("rq_rst_irq", 32'(o_irq), 32'd0);
        tick(1);
        i_ack = 1'b0; i_tf0 = 1'b0; i_rst = 1'b0;
        tick(1);
        chk("rq_no_pulse", 32'(o_clr_tf0), 32'd0);
        chk("rq_isr", 32'({o_isr_hi, o_isr_lo}), 32'd0);
        tick(1);
        chk("rq_idle_irq", 32'(o_irq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on each external interrupt pin (legal values 2 to 3).
REQ-002 The block SHALL have parameter VEC_BASE, default 16'h0003, meaning the vector of source 0; source n vector = VEC_BASE + 8*n.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset, stated exactly so; ports i_clk (in, 1, clock) and i_rst (in, 1, asynchronous active-high reset) come first.
REQ-004 The block SHALL have port i_ie, in, 8 bits: IE SFR with EA=bit7, ES=bit4, ET1=bit3, EX1=bit2, ET0=bit1, EX0=bit0.
REQ-005 The block SHALL have port i_ip, in, 8 bits: IP SFR with PS=bit4, PT1=bit3, PX1=bit2, PT0=bit1, PX0=bit0; 1 = high priority.
REQ-006 The block SHALL have ports i_it0 and i_it1, in, 1 bit each: INTx trigger type, 1 = falling edge, 0 = low level.
REQ-007 The block SHALL have ports i_int0_n and i_int1_n, in, 1 bit each: asynchronous external interrupt pins, active low.
REQ-008 The block SHALL have ports i_tf0, i_tf1, i_ri and i_ti, in, 1 bit each: timer overflow flags and serial flags.
REQ-009 The block SHALL have ports i_clr_ie0 and i_clr_ie1, in, 1 bit each: software write clearing the IE0/IE1 flag.
REQ-010 The block SHALL have port i_ack, in, 1 bit: CPU accepts the pending request at an instruction boundary (1-cycle pulse).
REQ-011 The block SHALL have port i_reti, in, 1 bit: CPU executed RETI (1-cycle pulse).
REQ-012 The block SHALL have ports o_irq, out, 1 bit (request to CPU), and o_vector, out, 16 bits (vector of the latched source).
REQ-013 The block SHALL have ports o_clr_tf0 and o_clr_tf1, out, 1 bit each: 1-cycle hardware clear pulses to the timers.
REQ-014 The block SHALL have ports o_ie0 and o_ie1, out, 1 bit each: external interrupt flags, mirrored to TCON[1] and TCON[3].
REQ-015 The block SHALL have ports o_isr_hi and o_isr_lo, out, 1 bit each: high-level and low-level in-service status.

Function
REQ-016 Each INTx pin SHALL pass through SYNC_STAGES flops; in edge mode, a 1-to-0 transition of the synchronized value SHALL set IEx on the next edge, so IEx is visible SYNC_STAGES+1 edges after the first edge sampling low.
REQ-017 In level mode, IEx SHALL equal the registered inverse of the synchronized pin, with the same latency as REQ-016.
REQ-018 In edge mode, IEx SHALL be cleared by i_clr_iex or by vectoring; set and clear in the same cycle SHALL leave IEx set.
REQ-019 Sources SHALL be indexed 0=IE0, 1=TF0, 2=IE1, 3=TF1, 4=RI|TI; source n SHALL be eligible when its flag=1, its enable bit=1 and EA=1.
REQ-020 Arbitration SHALL select the highest IP level first, then the lowest index within that level.
REQ-021 A high-level candidate SHALL be allowed when o_isr_hi=0; a low-level candidate SHALL be allowed only when o_isr_hi=0 and o_isr_lo=0.
REQ-022 The FSM SHALL have states IDLE and REQ.
REQ-023 In IDLE, when an allowed eligible source exists and i_reti=0, the FSM SHALL latch its index and level and go to REQ; o_irq SHALL be 1 and o_vector valid on the next cycle.
REQ-024 In REQ, o_irq, the latched index and o_vector SHALL hold stable; a newly arriving higher-priority source SHALL NOT re-arbitrate.
REQ-025 In REQ with i_ack=1, the FSM SHALL set the in-service bit of the latched level, emit the clear pulse on the next cycle (o_clr_tf0/1 for timers; IEx clear if edge mode; none for level mode or serial), and return to IDLE.
REQ-026 In REQ, if the latched source stops being eligible and i_ack=0, the FSM SHALL return to IDLE with o_irq=0 and no side effects.
REQ-027 i_ack SHALL be ignored in IDLE.
REQ-028 i_reti SHALL clear o_isr_hi if it is set, else o_isr_lo; i_reti with neither set SHALL be ignored.
REQ-029 On simultaneous i_reti and i_ack, i_reti SHALL be applied first and the i_ack level set second.

Reset
REQ-030 On i_rst, all outputs SHALL be asynchronously forced as follows: FSM=IDLE, o_irq=0, o_vector=16'h0000, clear pulses=0, o_ie0=o_ie1=0, o_isr_hi=o_isr_lo=0, synchronizer and previous-value flops=1.
REQ-031 Reset asserted in REQ SHALL drop o_irq immediately, and no clear pulse SHALL follow.

Verification
REQ-032 The bench SHALL cover: IE=8'h82, i_tf0 rises -> o_irq=1 one cycle later with o_vector=16'h000B; ack -> o_clr_tf0 pulses once and o_isr_lo=1.
REQ-033 The bench SHALL cover: IE=8'h8A, TF0 and TF1 rise in the same cycle with IP=0 -> vector 16'h000B; with IP=8'h08 -> vector 16'h001B.
REQ-034 The bench SHALL cover: low-level TF0 in service, TF1 high (IP=8'h08) -> o_irq with vector 16'h001B; a second low-level source stays blocked until two i_reti pulses.
REQ-035 The bench SHALL cover: IT0=1, i_int0_n pulses low for 3 cycles, EX0=0 -> o_ie0 set at SYNC_STAGES+1 edges and held; setting EX0=1 and EA=1 -> vector 16'h0003, and ack clears o_ie0.
REQ-036 The bench SHALL cover: REQ for TF1, then ET1 cleared before ack -> o_irq drops, no o_clr_tf1 pulse, o_isr_lo=0.
REQ-037 The bench SHALL cover: i_rst asserted mid-REQ -> o_irq=0 at the same time, with no later pulse.
